// File: rtl/uart_sample_deframer.sv
// Byte-stream deframer: SYNC, LEN, LEN x (LSB, MSB) [, CSUM] into a sample FIFO.
// Define DEFRAMER_CHECKSUM_EN to add a trailing XOR checksum byte per frame.
module uart_sample_deframer #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         FIFO_DEPTH     = 4,
    parameter int         TIMEOUT_CYCLES = 50_000
) (
    input  logic        clkIn,
    input  logic        nResetIn,
    input  logic [7:0]  rxDataIn,
    input  logic        rxReadyIn,
    output logic [15:0] sampleOut,
    output logic        sampleValidOut,
    input  logic        sampleReadyIn,
    output logic        frameDoneOut,
    output logic        errorOut,
    output logic        overflowOut
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_LSB,
        S_MSB
`ifdef DEFRAMER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] lsb_q, lsb_d;
    logic push_q, push_d;
    logic [15:0] push_data_q, push_data_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic done_q, done_d;
    logic err_q, err_d;
    logic ovf_q, ovf_d;
    logic [15:0] mem_q [FIFO_DEPTH];
    logic [15:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
`ifdef DEFRAMER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
`endif

    logic tmo_hit;
    logic do_pop;
    logic do_push;

    // Idle too long inside a frame; a strobe this cycle always rescues it
    assign tmo_hit = (state_q != S_HUNT) && !rxReadyIn && (tmo_q == TMO_LAST);

    // State register
    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) state_q <= S_HUNT;
        else           state_q <= state_d;
    end

    // Next-state: advance only on a byte strobe, timeout forces HUNT
    always_comb begin
        state_d = state_q;
        if (tmo_hit) begin
            state_d = S_HUNT;
        end else if (rxReadyIn) begin
            unique case (state_q)
                S_HUNT: if (rxDataIn == SYNC_BYTE) state_d = S_LEN;
                S_LEN:  state_d = (rxDataIn == 8'd0) ? S_HUNT : S_LSB;
                S_LSB:  state_d = S_MSB;
                S_MSB: begin
`ifdef DEFRAMER_CHECKSUM_EN
                    state_d = (cnt_q == 8'd1) ? S_CSUM : S_LSB;
`else
                    state_d = (cnt_q == 8'd1) ? S_HUNT : S_LSB;
`endif
                end
`ifdef DEFRAMER_CHECKSUM_EN
                S_CSUM: state_d = S_HUNT;
`endif
                default: state_d = S_HUNT;
            endcase
        end
    end

    // Output decode: frame-done and error pulses, registered below
    always_comb begin
        done_d = 1'b0;
        err_d  = 1'b0;
        if (tmo_hit) begin
            err_d = 1'b1;
        end else if (rxReadyIn) begin
            unique case (state_q)
                S_LEN: err_d = (rxDataIn == 8'd0);
`ifdef DEFRAMER_CHECKSUM_EN
                S_CSUM: begin
                    done_d = (rxDataIn == csum_q);
                    err_d  = (rxDataIn != csum_q);
                end
`else
                S_MSB: done_d = (cnt_q == 8'd1);
`endif
                default: ;
            endcase
        end
    end

    // Frame datapath: sample counter, low byte, staged push, idle timer
    always_comb begin
        cnt_d       = cnt_q;
        lsb_d       = lsb_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
`ifdef DEFRAMER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        if (rxReadyIn || state_q == S_HUNT || tmo_hit) tmo_d = '0;
        else                                           tmo_d = tmo_q + TW'(1);
        if (rxReadyIn) begin
            unique case (state_q)
                S_LEN: begin
                    cnt_d = rxDataIn;
`ifdef DEFRAMER_CHECKSUM_EN
                    csum_d = rxDataIn;
`endif
                end
                S_LSB: begin
                    lsb_d = rxDataIn;
`ifdef DEFRAMER_CHECKSUM_EN
                    csum_d = csum_q ^ rxDataIn;
`endif
                end
                S_MSB: begin
                    push_d      = 1'b1;
                    push_data_d = {rxDataIn, lsb_q};
                    cnt_d       = cnt_q - 8'd1;
`ifdef DEFRAMER_CHECKSUM_EN
                    csum_d = csum_q ^ rxDataIn;
`endif
                end
                default: ;
            endcase
        end
    end

    // Sample FIFO: push from staged sample, pop on valid/ready
    always_comb begin
        do_pop  = (count_q != '0) && sampleReadyIn;
        do_push = push_q && ((count_q != FULL_CNT) || do_pop);
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = push_data_q;
        wr_d    = do_push ? wr_q + PW'(1) : wr_q;
        rd_d    = do_pop  ? rd_q + PW'(1) : rd_q;
        count_d = count_q;
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (!do_push && do_pop) count_d = count_q - CW'(1);
        ovf_d   = ovf_q | (push_q & ~do_push);
    end

    // Datapath and FIFO registers
    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) begin
            cnt_q       <= '0;
            lsb_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            tmo_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef DEFRAMER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            lsb_q       <= lsb_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            tmo_q       <= tmo_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            count_q     <= count_d;
            mem_q       <= mem_d;
`ifdef DEFRAMER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign sampleOut      = mem_q[rd_q];
    assign sampleValidOut = (count_q != '0);
    assign frameDoneOut   = done_q;
    assign errorOut       = err_q;
    assign overflowOut    = ovf_q;

endmodule
